dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request/response interface.
- Accepts one word request per cycle over a valid/ready channel and commits writes using byte strobes.
- Returns exactly one in-order response per request, read or write, after a fixed pipeline latency, with backpressure on the response side.
- Sits behind the core's load/store path as the backing store for data space; it flags a fault instead of accessing memory on bad addresses.

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder_resp_fifo.sv | 63 ++++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and defaults for the data-memory responder
package dmem_responder_pkg;

  // One queued response: read data (zero for writes and faults) plus fault flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_resp_t;

  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1000_0000;
  localparam int          DMEM_DEPTH_WORDS = 1024;
  localparam int          DMEM_LATENCY     = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response channel between core load/store path and data memory
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_resp_fifo.sv
// rtl/dmem_responder_resp_fifo.sv - first-word-fall-through response FIFO with registered storage
module resp_fifo
  import dmem_responder_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = dmem_resp_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  T                 push_data_i,
  input  logic             pop_i,
  output T                 pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  // Popping an empty FIFO is ignored; push while full is only legal with a pop, which the owner guarantees.
  assign do_pop = pop_i && !empty_o;

  // Payload storage; the head is only consumed while non-empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers wrap modulo DEPTH (not necessarily a power of two); count resolves full vs empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_q];
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory backing store with fixed-latency, in-order, credit-limited responses
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          LATENCY     = DMEM_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic             busy
);

  localparam int RESP_DEPTH = LATENCY + 1;
  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int CRED_W     = $clog2(RESP_DEPTH + 1);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [CRED_W-1:0] credit_q;
  logic [CRED_W-1:0] credit_d;
  logic              accept;
  logic              pop;
  logic              fault;
  logic [IDX_W-1:0]  idx;
  dmem_resp_t        s0_resp;
  dmem_resp_t        push_resp;
  dmem_resp_t        head_resp;
  logic              push_v;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CRED_W-1:0] fifo_count;
  logic              unused_fifo;

  // BASE_ADDR is aligned to the array size, so the in-range test reduces to matching the upper bits.
  assign idx   = bus.req_addr[IDX_W+1:2];
  assign fault = (bus.req_addr[1:0] != 2'b00) ||
                 (bus.req_addr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2]);

  // Credits cover everything in the pipeline plus the FIFO, so the FIFO can never overflow.
  assign bus.req_ready = (credit_q < CRED_W'(RESP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.resp_valid && bus.resp_ready;
  assign busy          = (credit_q != '0);

  // Next credit value: accept and pop in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    if (accept && !pop) begin
      credit_d = credit_q + 1'b1;
    end else if (!accept && pop) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // Outstanding-request counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  // Byte-lane write commit at the acceptance edge; faulting requests never touch the array.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response formed in the acceptance cycle; the single port means this read never races a write.
  always_comb begin
    s0_resp.err   = fault;
    s0_resp.rdata = (fault || bus.req_we) ? 32'h0 : mem_q[idx];
  end

  // LATENCY-1 register stages; the FIFO's registered storage supplies the final cycle of latency.
  if (LATENCY == 1) begin : g_nopipe
    assign push_v    = accept;
    assign push_resp = s0_resp;
  end else begin : g_pipe
    logic       pipe_v_q [LATENCY-1];
    dmem_resp_t pipe_r_q [LATENCY-1];

    // Shift accepted responses toward the FIFO, one stage per cycle; never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          pipe_v_q[i] <= 1'b0;
          pipe_r_q[i] <= '0;
        end
      end else begin
        pipe_v_q[0] <= accept;
        pipe_r_q[0] <= s0_resp;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_v_q[i] <= pipe_v_q[i-1];
          pipe_r_q[i] <= pipe_r_q[i-1];
        end
      end
    end

    assign push_v    = pipe_v_q[LATENCY-2];
    assign push_resp = pipe_r_q[LATENCY-2];
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (dmem_resp_t)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_v),
    .push_data_i (push_resp),
    .pop_i       (pop),
    .pop_data_o  (head_resp),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign unused_fifo = ^{fifo_full, fifo_count};

  // Head fields are forced to zero while empty so stale or unwritten storage never shows.
  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_rdata = fifo_empty ? 32'h0 : head_resp.rdata;
  assign bus.resp_err   = !fifo_empty && head_resp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a queue model
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          LAT        = 2;
  localparam int          RESP_DEPTH = LAT + 1;
  localparam int          WORDS      = 1024;
  localparam logic [31:0] BASE       = 32'h1000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (WORDS),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [WORDS];
  exp_t        expq [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dut_acc = 0;
  int          dut_stall = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted request, straight from the address map and strobe rules.
  function automatic exp_t model_req(input logic we, input logic [31:0] addr,
                                     input logic [3:0] strb, input logic [31:0] wd, input int now);
    exp_t        e;
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    int          k;
    a  = {1'b0, addr};
    lo = {1'b0, BASE};
    hi = lo + 33'(4 * WORDS);
    e.due = now + LAT;
    if (a < lo || a >= hi || addr[1:0] != 2'b00) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
    end else begin
      k     = int'((a - lo) / 4);
      e.err = 1'b0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) ref_mem[k][8*b +: 8] = wd[8*b +: 8];
        end
        e.rdata = 32'h0;
      end else begin
        e.rdata = ref_mem[k];
      end
    end
    return e;
  endfunction

  // One clock cycle: drive, check DUT against model, advance model by the handshakes it predicts.
  task automatic step(input logic v, input logic we, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd, input logic rr);
    logic exp_ready;
    logic exp_valid;
    exp_t e;
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wstrb  = strb;
    bus.req_wdata  = wd;
    bus.resp_ready = rr;
    #1;
    exp_ready = (expq.size() < RESP_DEPTH);
    exp_valid = (expq.size() > 0) && (expq[0].due <= cyc);
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", busy, expq.size() != 0);
    check("resp_valid", bus.resp_valid, exp_valid);
    if (exp_valid) begin
      check("resp_rdata", bus.resp_rdata, expq[0].rdata);
      check("resp_err", bus.resp_err, expq[0].err);
    end
    if (v && bus.req_ready) dut_acc++;
    if (v && !bus.req_ready) dut_stall++;
    if (exp_valid && rr) begin
      last_rdata = bus.resp_rdata;
      last_err   = bus.resp_err;
      void'(expq.pop_front());
    end
    if (v && exp_ready) begin
      e = model_req(we, addr, strb, wd, cyc);
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && expq.size() > 0; k++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
      1:       return BASE - 32'(4 * $urandom_range(1, 4));
      2:       return BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 4));
      default: return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int a0;
    int s0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wstrb  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Preload every word so later reads have defined contents.
    for (int i = 0; i < WORDS; i++) step(1'b1, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom, 1'b1);
    drain();

    // Full write then read back.
    step(1'b1, 1'b1, 32'h1000_0010, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 32'h1000_0010, 4'h0, 32'h0, 1'b1);
    drain();
    check("rd_full_word", last_rdata, 32'hDEADBEEF);

    // Single-lane strobe merge.
    step(1'b1, 1'b1, 32'h1000_0010, 4'b0010, 32'h0000_AB00, 1'b1);
    step(1'b1, 1'b0, 32'h1000_0010, 4'h0, 32'h0, 1'b1);
    drain();
    check("rd_strobe_merge", last_rdata, 32'hDEADABEF);

    // Faults, zero-strobe write, faulting writes; array must be unchanged.
    step(1'b1, 1'b0, 32'h1000_0012, 4'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0FFF_FFFC, 4'h0, 32'h0, 1'b1);
    drain();
    check("fault_err", last_err, 1'b1);
    check("fault_rdata", last_rdata, 32'h0);
    step(1'b1, 1'b1, 32'h1000_0010, 4'h0, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0011, 4'hF, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b1, 32'h1000_1010, 4'hF, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b0, 32'h1000_0010, 4'h0, 32'h0, 1'b1);
    drain();
    check("rd_after_faults", last_rdata, 32'hDEADABEF);

    // Backpressure: only RESP_DEPTH requests fit, then release and drain in order.
    a0 = dut_acc;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, BASE + 32'(4 * k), 4'h0, 32'h0, 1'b0);
    check("bp_accepts", 32'(dut_acc - a0), 32'(RESP_DEPTH));
    check("bp_ready_low", bus.req_ready, 1'b0);
    drain();

    // Sustained streaming with no stalls.
    a0 = dut_acc;
    s0 = dut_stall;
    for (int k = 0; k < 64; k++)
      step(1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 4'h0, 32'h0, 1'b1);
    check("stream_stalls", 32'(dut_stall - s0), 32'h0);
    check("stream_accepts", 32'(dut_acc - a0), 32'd64);
    drain();

    // Asynchronous reset with responses outstanding; array contents survive.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, BASE + 32'(4 * k), 4'h0, 32'h0, 1'b0);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", bus.resp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b1);
    expq.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    last_rdata = '0;
    step(1'b1, 1'b0, 32'h1000_0010, 4'h0, 32'h0, 1'b1);
    drain();
    check("post_reset_read", last_rdata, 32'hDEADABEF);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
           4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
